// File: rtl/multibyte_add_sequencer_if.sv
// Operand/result handshake bundle for multibyte_add_sequencer.
// The sub signal exists only when ADDSEQ_SUB_EN is defined.
interface multibyte_add_sequencer_if #(parameter int NBYTES = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  cin;
`ifdef ADDSEQ_SUB_EN
  logic                  sub;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  cout;

  modport master (
    output in_valid, a, b, cin,
`ifdef ADDSEQ_SUB_EN
    output sub,
`endif
    input  in_ready,
    input  out_valid, sum, cout,
    output out_ready
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADDSEQ_SUB_EN
    input  sub,
`endif
    output in_ready,
    output out_valid, sum, cout,
    input  out_ready
  );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision adder around one 8-bit carry-select adder, LSB first.
// Optional subtract mode (a - b) is enabled by defining ADDSEQ_SUB_EN.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multibyte_add_sequencer_if.slave      bus,
  output logic                          busy
);
  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // RUN   | adding byte idx, carry registered between bytes
  // DONE  | result held on sum/cout until the consumer takes it
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic          sub_q;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic [7:0]    add_s;
  logic          add_co;
  logic [4:0]    lo;
  logic [4:0]    hi0;
  logic [4:0]    hi1;
  logic [W-1:0]  sum_next;

`ifndef ADDSEQ_SUB_EN
  assign sub_q = 1'b0;
`endif

  // Carry-select byte adder: both upper-nibble sums precomputed, low carry picks one.
  always_comb begin
    add_a    = a_q[8*idx +: 8];
    add_b    = b_q[8*idx +: 8] ^ {8{sub_q}};
    lo       = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]} + {4'b0, carry};
    hi0      = {1'b0, add_a[7:4]} + {1'b0, add_b[7:4]};
    hi1      = hi0 + 5'd1;
    add_s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
    add_co   = lo[4] ? hi1[4] : hi0[4];
    sum_next = sum_q;
    sum_next[8*idx +: 8] = add_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      carry         <= 1'b0;
      sum_q         <= '0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            a_q          <= bus.a;
            b_q          <= bus.b;
`ifdef ADDSEQ_SUB_EN
            sub_q        <= bus.sub;
            carry        <= bus.cin | bus.sub;
`else
            carry        <= bus.cin;
`endif
            sum_q        <= '0;
            idx          <= '0;
            state        <= RUN;
            bus.in_ready <= 1'b0;
            busy         <= 1'b1;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          carry <= add_co;
          // Result register is loaded once, so sum never shows partial bytes.
          if (idx == LAST) begin
            state         <= DONE;
            bus.sum       <= sum_next;
            bus.cout      <= add_co;
            bus.out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_valid && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Directed bench for multibyte_add_sequencer: a 4-byte and a 1-byte instance.
// Subtract checks are compiled in when ADDSEQ_SUB_EN is defined.
module tb_multibyte_add_sequencer;
  logic clk;
  logic rst_n;
  logic busy4;
  logic busy1;
  int   checks;
  int   errors;

  multibyte_add_sequencer_if #(.NBYTES(4)) bus4 ();
  multibyte_add_sequencer_if #(.NBYTES(1)) bus1 ();

  multibyte_add_sequencer #(.NBYTES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4));
  multibyte_add_sequencer #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] v1a [4] = '{8'h80, 8'h01, 8'hFF, 8'h7F};
  logic [7:0] v1b [4] = '{8'h80, 8'h02, 8'hFF, 8'h01};
  logic       v1c [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] e1s [4] = '{8'h00, 8'h04, 8'hFF, 8'h80};
  logic       e1c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  // Accepts one operand set on bus4 and returns at the negedge where out_valid is seen.
  task automatic run_op4(input logic [31:0] av, input logic [31:0] bv, input logic c,
                         output int lat);
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.a = av;
    bus4.b = bv;
    bus4.cin = c;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    lat = 1;
    while (!bus4.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take4();
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || busy4 !== 1'b0 ||
        bus4.sum !== 32'h0 || bus4.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset4 got ov=%b ir=%b busy=%b sum=%h cout=%b exp 0 1 0 0 0",
               bus4.out_valid, bus4.in_ready, busy4, bus4.sum, bus4.cout);
    end
    checks++;
    if (bus1.out_valid !== 1'b0 || bus1.in_ready !== 1'b1 || busy1 !== 1'b0 ||
        bus1.sum !== 8'h0 || bus1.cout !== 1'b0) begin
      errors++;
      $display("FAIL reset1 got ov=%b ir=%b busy=%b sum=%h cout=%b exp 0 1 0 0 0",
               bus1.out_valid, bus1.in_ready, busy1, bus1.sum, bus1.cout);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_ripple();
    int lat;
    run_op4(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL latency4 got %0d exp 5", lat);
    end
    checks++;
    if (bus4.sum !== 32'h00000000 || bus4.cout !== 1'b1) begin
      errors++;
      $display("FAIL ripple got sum=%h cout=%b exp 00000000 1", bus4.sum, bus4.cout);
    end
    checks++;
    if (bus4.in_ready !== 1'b0 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL done_flags got ir=%b busy=%b exp 0 1", bus4.in_ready, busy4);
    end
    take4();
  endtask

  task automatic test_cin();
    int lat;
    run_op4(32'h12345678, 32'h11111111, 1'b1, lat);
    checks++;
    if (bus4.sum !== 32'h2345678A || bus4.cout !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL cin_add got sum=%h cout=%b lat=%0d exp 2345678A 0 5",
               bus4.sum, bus4.cout, lat);
    end
    take4();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op4(32'h89ABCDEF, 32'h76543210, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.sum !== 32'hFFFFFFFF || bus4.cout !== 1'b0 ||
          bus4.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got ov=%b sum=%h cout=%b ir=%b exp 1 FFFFFFFF 0 0",
                 i, bus4.out_valid, bus4.sum, bus4.cout, bus4.in_ready);
      end
      @(negedge clk);
    end
    take4();
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1 || busy4 !== 1'b0 ||
        bus4.sum !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL release got ov=%b ir=%b busy=%b sum=%h exp 0 1 0 FFFFFFFF",
               bus4.out_valid, bus4.in_ready, busy4, bus4.sum);
    end
  endtask

  task automatic test_abort();
    int lat;
    @(negedge clk);
    bus4.in_valid = 1'b1;
    bus4.a = 32'h01010101;
    bus4.b = 32'h02020202;
    bus4.cin = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b1 || bus4.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_flags got busy=%b ir=%b exp 1 0", busy4, bus4.in_ready);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.sum !== 32'h0 || bus4.cout !== 1'b0 ||
        busy4 !== 1'b0 || bus4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort got ov=%b sum=%h cout=%b busy=%b ir=%b exp 0 0 0 0 1",
               bus4.out_valid, bus4.sum, bus4.cout, busy4, bus4.in_ready);
    end
    rst_n = 1'b1;
    run_op4(32'h00000001, 32'h00000002, 1'b0, lat);
    checks++;
    if (bus4.sum !== 32'h00000003 || bus4.cout !== 1'b0 || lat !== 5) begin
      errors++;
      $display("FAIL after_abort got sum=%h cout=%b lat=%0d exp 00000003 0 5",
               bus4.sum, bus4.cout, lat);
    end
    take4();
  endtask

`ifdef ADDSEQ_SUB_EN
  task automatic test_sub();
    int lat;
    bus4.sub = 1'b1;
    run_op4(32'h00000000, 32'h00000001, 1'b0, lat);
    checks++;
    if (bus4.sum !== 32'hFFFFFFFF || bus4.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow got sum=%h cout=%b exp FFFFFFFF 0", bus4.sum, bus4.cout);
    end
    take4();
    run_op4(32'h00000005, 32'h00000003, 1'b0, lat);
    checks++;
    if (bus4.sum !== 32'h00000002 || bus4.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_plain got sum=%h cout=%b exp 00000002 1", bus4.sum, bus4.cout);
    end
    take4();
    bus4.sub = 1'b0;
    run_op4(32'h00000005, 32'h00000003, 1'b1, lat);
    checks++;
    if (bus4.sum !== 32'h00000009 || bus4.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_off got sum=%h cout=%b exp 00000009 0", bus4.sum, bus4.cout);
    end
    take4();
  endtask
`endif

  task automatic test_single_byte();
    int lat;
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.a = 8'h80;
    bus1.b = 8'h80;
    bus1.cin = 1'b0;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 1;
    while (!bus1.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (bus1.sum !== 8'h00 || bus1.cout !== 1'b1 || lat !== 2) begin
      errors++;
      $display("FAIL nb1_op got sum=%h cout=%b lat=%0d exp 00 1 2", bus1.sum, bus1.cout, lat);
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int vi;
    int ri;
    int last_acc;
    vi = 0;
    ri = 0;
    last_acc = -1;
    bus1.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && ri < 4; cyc++) begin
      if (bus1.out_valid) begin
        checks++;
        if (bus1.sum !== e1s[ri] || bus1.cout !== e1c[ri]) begin
          errors++;
          $display("FAIL b2b_res[%0d] got sum=%h cout=%b exp %h %b",
                   ri, bus1.sum, bus1.cout, e1s[ri], e1c[ri]);
        end
        ri++;
      end
      if (bus1.in_ready && vi < 4) begin
        bus1.in_valid = 1'b1;
        bus1.a = v1a[vi];
        bus1.b = v1b[vi];
        bus1.cin = v1c[vi];
        if (vi > 0) begin
          checks++;
          if (cyc - last_acc !== 3) begin
            errors++;
            $display("FAIL b2b_interval[%0d] got %0d exp 3", vi, cyc - last_acc);
          end
        end
        last_acc = cyc;
        vi++;
      end else begin
        bus1.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    checks++;
    if (ri !== 4) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 4", ri);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.cin = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.a = '0;
    bus1.b = '0;
    bus1.cin = 1'b0;
    bus1.out_ready = 1'b0;
`ifdef ADDSEQ_SUB_EN
    bus4.sub = 1'b0;
    bus1.sub = 1'b0;
`endif
    test_reset();
    test_carry_ripple();
    test_cin();
    test_backpressure();
    test_abort();
`ifdef ADDSEQ_SUB_EN
    test_sub();
`endif
    test_single_byte();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
